// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer and its environment.
// master drives lock and soft-reset inputs; slave (the sequencer) drives resets and status.
interface rst_seq_ctrl_if #(
  parameter int STAGES = 4
) ();
  logic              vpx_locked;
  logic              soft_rst_req;
  logic [STAGES-1:0] rst_out;
  logic              all_rdy;
  logic [1:0]        seq_state;
  logic [15:0]       lock_loss_cnt;

  modport master (
    output vpx_locked,
    output soft_rst_req,
    input  rst_out,
    input  all_rdy,
    input  seq_state,
    input  lock_loss_cnt
  );

  modport slave (
    input  vpx_locked,
    input  soft_rst_req,
    output rst_out,
    output all_rdy,
    output seq_state,
    output lock_loss_cnt
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: qualifies vpx_locked, then releases domains in ascending order.
// Lock loss re-asserts all domains SYNC_STAGES+1 edges after the input falls; no backpressure.
module rst_seq_ctrl #(
  parameter int STAGES      = 4,
  parameter int STAGE_DLY   = 1000,
  parameter int LOCK_STABLE = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_100m,
  input  logic          rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int CNT_MAX = (LOCK_STABLE > STAGE_DLY) ? LOCK_STABLE : STAGE_DLY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(STAGES + 1);

  localparam logic [CW-1:0] STABLE_TC = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] DLY_TC    = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_ASSERT  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q;
  logic [CW-1:0]          stable_cnt_q;
  logic [CW-1:0]          dly_cnt_q;
  logic [IW-1:0]          idx_q;
  logic [STAGES-1:0]      rst_out_q;
  logic                   all_rdy_q;
  logic [15:0]            lock_loss_cnt_q;
  logic [15:0]            lock_loss_cnt_d;

  assign lock_s          = sync_q[SYNC_STAGES-1];
  assign lock_loss_cnt_d = (lock_loss_cnt_q == 16'hFFFF) ? lock_loss_cnt_q
                                                         : lock_loss_cnt_q + 16'd1;

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.vpx_locked};
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q         <= S_HOLD;
      stable_cnt_q    <= '0;
      dly_cnt_q       <= '0;
      idx_q           <= '0;
      rst_out_q       <= '1;
      all_rdy_q       <= 1'b0;
      lock_loss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (!lock_s) begin
            stable_cnt_q <= '0;
          end else if (stable_cnt_q == STABLE_TC) begin
            state_q      <= S_RELEASE;
            stable_cnt_q <= '0;
            dly_cnt_q    <= '0;
            idx_q        <= '0;
          end else begin
            stable_cnt_q <= stable_cnt_q + CW'(1);
          end
        end

        // Lock loss outranks a simultaneous software request.
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state_q         <= S_HOLD;
            rst_out_q       <= '1;
            all_rdy_q       <= 1'b0;
            stable_cnt_q    <= '0;
            lock_loss_cnt_q <= lock_loss_cnt_d;
          end else if (bus.soft_rst_req) begin
            state_q   <= S_ASSERT;
            rst_out_q <= '1;
            all_rdy_q <= 1'b0;
            dly_cnt_q <= '0;
          end else if (state_q == S_RELEASE) begin
            if (dly_cnt_q == DLY_TC) begin
              // Shifting in zeros keeps the released bits contiguous from bit 0.
              dly_cnt_q <= '0;
              rst_out_q <= rst_out_q << 1;
              idx_q     <= idx_q + IW'(1);
              if (idx_q == LAST_IDX) begin
                state_q   <= S_RUN;
                all_rdy_q <= 1'b1;
              end
            end else begin
              dly_cnt_q <= dly_cnt_q + CW'(1);
            end
          end
        end

        S_ASSERT: begin
          if (!lock_s) begin
            state_q         <= S_HOLD;
            stable_cnt_q    <= '0;
            lock_loss_cnt_q <= lock_loss_cnt_d;
          end else if (dly_cnt_q == DLY_TC) begin
            state_q      <= S_HOLD;
            stable_cnt_q <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.rst_out       = rst_out_q;
  assign bus.all_rdy       = all_rdy_q;
  assign bus.seq_state     = state_q;
  assign bus.lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random lock/soft/reset traffic against a timing model.
module tb_rst_seq_ctrl;
  localparam int STAGES      = 4;
  localparam int STAGE_DLY   = 8;
  localparam int LOCK_STABLE = 16;
  localparam int SYNC_STAGES = 2;

  logic clk_100m = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_100m = ~clk_100m;

  rst_seq_ctrl_if #(.STAGES(STAGES)) bus ();

  rst_seq_ctrl #(
    .STAGES(STAGES), .STAGE_DLY(STAGE_DLY),
    .LOCK_STABLE(LOCK_STABLE), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_100m(clk_100m),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus "cycles since entering mode"; released domains derived by division.
  int m_mode = 0;
  int m_run  = 0;
  int m_t    = 0;
  int m_llc  = 0;
  bit m_hist[$];

  task automatic model_step();
    bit lock_s;
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
      m_mode = 0; m_run = 0; m_t = 0; m_llc = 0;
      return;
    end
    lock_s = m_hist[SYNC_STAGES-1];
    m_hist.push_front(bus.vpx_locked);
    void'(m_hist.pop_back());
    case (m_mode)
      0: begin
        if (!lock_s) m_run = 0;
        else if (m_run == LOCK_STABLE - 1) begin m_mode = 1; m_t = 0; m_run = 0; end
        else m_run++;
      end
      1, 2: begin
        if (!lock_s) begin
          m_mode = 0; m_run = 0;
          if (m_llc < 65535) m_llc++;
        end else if (bus.soft_rst_req) begin
          m_mode = 3; m_t = 0;
        end else if (m_mode == 1) begin
          m_t++;
          if (m_t == STAGES * STAGE_DLY) m_mode = 2;
        end
      end
      default: begin
        if (!lock_s) begin
          m_mode = 0; m_run = 0;
          if (m_llc < 65535) m_llc++;
        end else if (m_t == STAGE_DLY - 1) begin
          m_mode = 0; m_run = 0;
        end else m_t++;
      end
    endcase
  endtask

  function automatic logic [STAGES-1:0] exp_rst_out();
    logic [STAGES-1:0] ones;
    ones = '1;
    if (m_mode == 1) return ones << (m_t / STAGE_DLY);
    if (m_mode == 2) return '0;
    return ones;
  endfunction

  always @(posedge clk_100m) model_step();

  always @(negedge clk_100m) begin
    check("rst_out", 32'(bus.rst_out), 32'(exp_rst_out()));
    check("seq_state", 32'(bus.seq_state), 32'(m_mode));
    check("all_rdy", 32'(bus.all_rdy), 32'(m_mode == 2));
    check("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_llc));
  end

  task automatic tick();
    @(negedge clk_100m);
  endtask

  task automatic wait_state(input int want, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.seq_state != 2'(want) && n < budget);
    check("wait_state", 32'(bus.seq_state), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low_left;
    bus.vpx_locked   = 1'b1;
    bus.soft_rst_req = 1'b0;
    rst              = 1'b1;

    // Power-up
    repeat (4) tick();
    check("reset_rst_out", 32'(bus.rst_out), 32'hF);
    check("reset_llc", 32'(bus.lock_loss_cnt), 32'd0);
    rst = 1'b0;
    wait_state(1, 100, n);
    check("release_entry_edges", 32'(n), 32'd18);
    wait_state(2, 100, n);
    check("run_after_release", 32'(n), 32'd32);
    check("run_all_rdy", 32'(bus.all_rdy), 32'd1);

    // Lock loss in RUN
    bus.vpx_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.rst_out != 4'hF && n < 10);
    check("loss_latency", 32'(n), 32'd3);
    check("loss_count", 32'(bus.lock_loss_cnt), 32'd1);
    bus.vpx_locked = 1'b1;
    wait_state(2, 200, n);

    // Soft request in RUN
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    check("soft_enter_assert", 32'(bus.seq_state), 32'd3);
    n = 1;
    while (bus.seq_state == 2'd3 && n < 20) begin tick(); n++; end
    check("assert_len", 32'(n - 1), 32'd8);
    check("soft_llc_same", 32'(bus.lock_loss_cnt), 32'd1);
    wait_state(2, 200, n);

    // Lock glitch during HOLD qualification
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    bus.vpx_locked = 1'b0;
    tick();
    bus.vpx_locked = 1'b1;
    wait_state(1, 100, n);
    check("glitch_release_entry", 32'(n + 13), 32'd31);

    // Collision: soft request on the edge lock_s is first seen low
    repeat (3) tick();
    bus.vpx_locked = 1'b0;
    tick();
    tick();
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    check("collision_state", 32'(bus.seq_state), 32'd0);
    check("collision_llc", 32'(bus.lock_loss_cnt), 32'd1);
    bus.vpx_locked = 1'b1;

    // Mid-sequence reset
    n = 0;
    do begin tick(); n++; end while (bus.rst_out != 4'hC && n < 200);
    check("reach_C", 32'(bus.rst_out), 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rst_out", 32'(bus.rst_out), 32'hF);
    check("midrst_state", 32'(bus.seq_state), 32'd0);
    check("midrst_llc", 32'(bus.lock_loss_cnt), 32'd0);
    wait_state(2, 200, n);
    check("midrst_run_edges", 32'(n), 32'd50);

    // Random traffic
    low_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (low_left > 0) begin
        low_left--;
        bus.vpx_locked = (low_left == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        low_left = $urandom_range(1, 6);
        bus.vpx_locked = 1'b0;
      end
      bus.soft_rst_req = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    bus.soft_rst_req = 1'b0;
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
